bus_trace_buffer: RTL and testbench
===================================

// Module: bus_trace_buffer
// PURPOSE
//  Passive recorder for the 8088 system bus inside mpe. Watches command strobes (MRDC/MWTC/IORC/IOWC/INTA),
//  logs each completed cycle as {type, addr, data[, timestamp]} into a DEPTH-entry FIFO, and drains it via a
//  valid/ready port to the UART dumper or a bench. Replaces ad-hoc waveform inspection with a parametrised,
//  self-describing bus trace; adds stop/ring modes, type filter and loss accounting.
// PARAMETERS
//  ADDR_W  20  bus address width (20 = full 8088 space; 16 for I/O-only traces)
//  DEPTH   16  FIFO entries; power of two, >= 2
//  CNT_W   16  width of dropped-record counter
//  TS_W    16  timestamp width (used only with BUS_TRACE_TIMESTAMP_EN)
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  rst_n        in   1       asynchronous active-low reset
//  bus_addr     in   ADDR_W  CPU address bus (latched address)
//  bus_data     in   8       CPU data bus
//  mrdc_n       in   1       memory read command, active low
//  mwtc_n       in   1       memory write command, active low
//  iorc_n       in   1       I/O read command, active low
//  iowc_n       in   1       I/O write command, active low
//  inta_n       in   1       interrupt acknowledge, active low
//  capture_en   in   1       1 = record completed cycles
//  ring_mode    in   1       0 = stop (drop newest when full), 1 = ring (overwrite oldest)
//  type_mask    in   5       bit k=1 records type k; bit k=0 suppresses it
//  clear        in   1       synchronous clear of FIFO, flags, counter
//  rd_valid     out  1       head record available
//  rd_ready     in   1       consumer accepts head record
//  rd_data      out  REC_W   head record, show-ahead; REC_W = 3+ADDR_W+8[+TS_W]
//  level        out  log2(DEPTH)+1  entries held
//  overflow     out  1       sticky: at least one record lost/overwritten
//  proto_err    out  1       sticky: >1 strobe low in same cycle
//  drop_cnt     out  CNT_W   records lost, saturating
// BEHAVIOUR
//  Reset: rd_valid=0, rd_data=0, level=0, overflow=0, proto_err=0, drop_cnt=0, pointers=0, all strobe_q=1.
//  Types: 0 MEMRD, 1 MEMWR, 2 IORD, 3 IOWR, 4 INTA. Record layout MSB->LSB: {[ts], type, addr, data}.
//  Each cycle a strobe is low, addr/data are registered (last-low-cycle values win; INTA logs its vector byte).
//  Completion = strobe sampled 1 while strobe_q=0 (rising edge). Push at that clock edge if capture_en=1
//   and type_mask[type]=1; rd_valid/level reflect it on the following cycle (1-cycle latency).
//  Multiple strobes low together: proto_err set; lowest type code is the one tracked, others ignored.
//  Pop at edge when rd_valid & rd_ready; rd_data moves to next entry same edge.
//  Full + push, no pop: stop mode -> new record dropped; ring mode -> oldest discarded, new written.
//   Both: overflow<=1, drop_cnt+=1 (saturates at 2^CNT_W-1, no wrap).
//  Full + push + pop same edge: both succeed, level stays DEPTH, no overflow.
//  Empty + push: rd_valid=0 that cycle, so no pop; level 0->1.
//  Pointers wrap modulo DEPTH; level = wr-rd with extra MSB distinguishing full from empty.
//  clear: highest priority; empties FIFO, zeroes flags/counter; a push in the same edge is discarded.
//   Edge detector keeps tracking (strobe_q not cleared).
//  capture_en=0: no pushes, no drops counted; a cycle that ends while disabled is never logged.
//  Reset mid-cycle: after rst_n release with a strobe still low, its rising edge is logged (strobe_q=1 at
//   reset means only low->high transitions seen after release count; a strobe low at release is recorded).
// CONFIGURATION
//  BUS_TRACE_TIMESTAMP_EN defined: free-running TS_W-bit cycle counter (reset 0, wraps) stamped at push
//   edge into rd_data MSBs; REC_W = 3+ADDR_W+8+TS_W.
//  Not defined: no counter, REC_W = 3+ADDR_W+8; all other behaviour identical.
// STRUCTURE
//  mpe_bus_pkg: type codes (TR_MEMRD..TR_INTA), type width 3, record field offset/width functions.
//  Sub-module bus_trace_fifo (storage array, pointers, level, full/empty, overwrite-oldest option);
//  top holds strobe edge detection, capture registers, filter, flags, drop counter, timestamp.
// TESTING
//  MEMWR addr 0x00100 data 0x5A, 3 low cycles -> 1 cycle after rise rd_valid=1, rd_data={1,0x00100,0x5A}.
//  IOWR 0x0040/0x36 then IORD 0x0041/0x12 with type_mask=5'b01000 -> only IOWR logged, level=1.
//  DEPTH=16 stop mode, 18 MEMRD, no reads -> level=16, overflow=1, drop_cnt=2, head=1st record.
//  Same in ring mode -> level=16, drop_cnt=2, head=3rd record, tail=18th.
//  Full, push coincident with rd_ready=1 -> one pop + one push, level=16, overflow stays 0.
//  mrdc_n and iorc_n low together -> proto_err=1, one MEMRD record; then clear -> level=0, flags=0.

Source files
------------

// File: rtl/mpe_bus_pkg.sv
// rtl/mpe_bus_pkg.sv - bus trace type codes, record layout helpers
package mpe_bus_pkg;

  localparam int TYPE_W    = 3;
  localparam int DATA_W    = 8;
  localparam int NUM_TYPES = 5;

  typedef enum logic [TYPE_W-1:0] {
    TR_MEMRD = 3'd0,
    TR_MEMWR = 3'd1,
    TR_IORD  = 3'd2,
    TR_IOWR  = 3'd3,
    TR_INTA  = 3'd4
  } tr_type_e;

  // Record layout, MSB->LSB: {[ts], type, addr, data}
  function automatic int rec_data_lsb();
    return 0;
  endfunction

  function automatic int rec_addr_lsb();
    return DATA_W;
  endfunction

  function automatic int rec_type_lsb(input int addr_w);
    return DATA_W + addr_w;
  endfunction

  function automatic int rec_ts_lsb(input int addr_w);
    return TYPE_W + DATA_W + addr_w;
  endfunction

  function automatic int rec_width(input int addr_w, input int ts_w);
    return TYPE_W + DATA_W + addr_w + ts_w;
  endfunction

  // Type code of the lowest set bit; TR_MEMRD when nothing is set
  function automatic tr_type_e lowest_type(input logic [NUM_TYPES-1:0] act);
    tr_type_e t;
    t = TR_MEMRD;
    for (int k = NUM_TYPES - 1; k >= 0; k--) begin
      if (act[k]) t = tr_type_e'(k[TYPE_W-1:0]);
    end
    return t;
  endfunction

endpackage

// File: rtl/bus_trace_fifo.sv
// rtl/bus_trace_fifo.sv - show-ahead record FIFO with stop/overwrite-oldest on full
module bus_trace_fifo
  import mpe_bus_pkg::*;
#(
  parameter  int WIDTH = 31,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             ring_mode,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [AW:0]      level,
  output logic             dropped
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, pop, wr_en;

  // Extra pointer MSB separates full (level=DEPTH) from empty (level=0)
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (level == FULL_LVL);
  assign m_tvalid = ~empty;
  assign pop      = m_tvalid & m_tready;
  assign m_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: clear wins, pop+push on full always succeeds, ring overwrites oldest
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    dropped  = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (s_tvalid) begin
        if (!full || pop) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          dropped = 1'b1;
          if (ring_mode) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are masked by empty so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_tdata;
  end

endmodule

// File: rtl/bus_trace_buffer.sv
// rtl/bus_trace_buffer.sv - 8088 bus cycle recorder; BUS_TRACE_TIMESTAMP_EN adds timestamps
module bus_trace_buffer
  import mpe_bus_pkg::*;
#(
  parameter  int ADDR_W = 20,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = 16,
  parameter  int TS_W   = 16,
`ifdef BUS_TRACE_TIMESTAMP_EN
  localparam int TS_EN  = 1,
`else
  localparam int TS_EN  = 0,
`endif
  localparam int REC_W  = rec_width(ADDR_W, TS_W * TS_EN),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    bus_addr,
  input  logic [DATA_W-1:0]    bus_data,
  input  logic                 mrdc_n,
  input  logic                 mwtc_n,
  input  logic                 iorc_n,
  input  logic                 iowc_n,
  input  logic                 inta_n,
  input  logic                 capture_en,
  input  logic                 ring_mode,
  input  logic [NUM_TYPES-1:0] type_mask,
  input  logic                 clear,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [REC_W-1:0]     rd_data,
  output logic [LVL_W-1:0]     level,
  output logic                 overflow,
  output logic                 proto_err,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic [NUM_TYPES-1:0] str_n, low;
  logic [NUM_TYPES-1:0] strobe_q, strobe_d;
  logic [NUM_TYPES-1:0] ign_q, ign_d;
  logic [NUM_TYPES-1:0] done, done_1h;
  logic [ADDR_W-1:0]    cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]    cap_data_q, cap_data_d;
  logic                 proto_err_q, proto_err_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  tr_type_e             done_type;
  logic                 push, fifo_drop;
  logic [REC_W-1:0]     rec;

  // Bit k of the strobe vectors corresponds to type code k
  assign str_n = {inta_n, iowc_n, iorc_n, mwtc_n, mrdc_n};
  assign low   = ~str_n;

  // A strobe seen low together with a lower-coded strobe stays ignored until it rises
  always_comb begin
    ign_d = '0;
    for (int k = 0; k < NUM_TYPES; k++) begin
      ign_d[k] = low[k] & (ign_q[k] | (|(low & ((5'd1 << k) - 5'd1))));
    end
  end

  // Completion detect, filter and record assembly
  always_comb begin
    strobe_d   = str_n;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    if (|low) begin
      cap_addr_d = bus_addr;
      cap_data_d = bus_data;
    end
    done      = str_n & ~strobe_q & ~ign_q;
    done_1h   = done & (~done + 5'd1);
    done_type = lowest_type(done_1h);
    push      = (|(done_1h & type_mask)) & capture_en & ~clear;
  end

  // Sticky flags and saturating loss counter; clear takes priority
  always_comb begin
    proto_err_d = proto_err_q | (|(low & (low - 5'd1)));
    overflow_d  = overflow_q | fifo_drop;
    drop_cnt_d  = drop_cnt_q;
    if (fifo_drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
    if (clear) begin
      proto_err_d = 1'b0;
      overflow_d  = 1'b0;
      drop_cnt_d  = '0;
    end
  end

  // Edge detector, capture and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q    <= '1;
      ign_q       <= '0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      proto_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      strobe_q    <= strobe_d;
      ign_q       <= ign_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      proto_err_q <= proto_err_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef BUS_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running cycle counter, stamped into the record at the push edge
  always_comb begin
    ts_d = ts_q + 1'b1;
  end

  // Timestamp register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign rec = {ts_q, done_type, cap_addr_q, cap_data_q};
`else
  assign rec = {done_type, cap_addr_q, cap_data_q};
`endif

  bus_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .ring_mode (ring_mode),
    .s_tdata   (rec),
    .s_tvalid  (push),
    .m_tdata   (rd_data),
    .m_tvalid  (rd_valid),
    .m_tready  (rd_ready),
    .level     (level),
    .dropped   (fifo_drop)
  );

  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// tb/tb_bus_trace_buffer.sv - self-checking bench for bus_trace_buffer
module tb_bus_trace_buffer;

  localparam int ADDR_W = 20;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int TS_W   = 16;
`ifdef BUS_TRACE_TIMESTAMP_EN
  localparam int REC_W  = 31 + TS_W;
`else
  localparam int REC_W  = 31;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_data;
  logic              mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n;
  logic [4:0]        sn;
  logic              capture_en, ring_mode, clear, rd_ready;
  logic [4:0]        type_mask;
  logic              rd_valid, overflow, proto_err;
  logic [REC_W-1:0]  rd_data;
  logic [4:0]        level;
  logic [CNT_W-1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of {type, addr, data} records
  logic [30:0] mq[$];
  int          m_drops;
  bit          m_ovf;

  assign {inta_n, iowc_n, iorc_n, mwtc_n, mrdc_n} = sn;

  always #5 clk = ~clk;

  bus_trace_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .TS_W   (TS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .mrdc_n     (mrdc_n),
    .mwtc_n     (mwtc_n),
    .iorc_n     (iorc_n),
    .iowc_n     (iowc_n),
    .inta_n     (inta_n),
    .capture_en (capture_en),
    .ring_mode  (ring_mode),
    .type_mask  (type_mask),
    .clear      (clear),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .level      (level),
    .overflow   (overflow),
    .proto_err  (proto_err),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    int          t;
    logic [19:0] a;
    logic [7:0]  d;
    int          nlow;
    logic [4:0]  mask;
    bit          cap;
    bit          exp_valid;
    logic [30:0] exp_rec;
  } vec_t;

  vec_t vt[7];

  function automatic logic [30:0] mk(input int t, input logic [19:0] a, input logic [7:0] d);
    logic [2:0] tt;
    tt = t[2:0];
    return {tt, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_log(input int t, input logic [19:0] a, input logic [7:0] d);
    if (!capture_en || !type_mask[t]) return;
    if (mq.size() < DEPTH) begin
      mq.push_back(mk(t, a, d));
    end else begin
      if (m_drops < 65535) m_drops++;
      m_ovf = 1'b1;
      if (ring_mode) begin
        void'(mq.pop_front());
        mq.push_back(mk(t, a, d));
      end
    end
  endtask

  task automatic bus_cycle(input int t, input logic [19:0] a, input logic [7:0] d, input int nlow);
    bus_addr = a;
    bus_data = d;
    sn       = ~(5'd1 << t);
    repeat (nlow) tick();
    sn = 5'h1F;
    tick();
    model_log(t, a, d);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".level"}, 64'(level), 64'(mq.size()));
    chk({tag, ".valid"}, 64'(rd_valid), 64'(mq.size() != 0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".drops"}, 64'(drop_cnt), 64'(m_drops));
    if (mq.size() != 0) chk({tag, ".head"}, 64'(rd_data[30:0]), 64'(mq[0]));
  endtask

  task automatic pop_check(input string tag);
    chk({tag, ".pop_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".pop_data"}, 64'(rd_data[30:0]), 64'(mq[0]));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    void'(mq.pop_front());
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_addr   = '0;
    bus_data   = '0;
    sn         = 5'h1F;
    capture_en = 1'b1;
    ring_mode  = 1'b0;
    type_mask  = 5'h1F;
    clear      = 1'b0;
    rd_ready   = 1'b0;
    m_drops    = 0;
    m_ovf      = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst.valid", 64'(rd_valid), 64'd0);
    chk("rst.data", 64'(rd_data), 64'd0);
    chk("rst.level", 64'(level), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    chk("rst.proto", 64'(proto_err), 64'd0);
    chk("rst.drops", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven single-cycle vectors, each from an empty buffer
    vt[0] = '{1, 20'h00100, 8'h5A, 3, 5'h1F, 1'b1, 1'b1, {3'd1, 20'h00100, 8'h5A}};
    vt[1] = '{0, 20'hFFFFF, 8'hA5, 1, 5'h1F, 1'b1, 1'b1, {3'd0, 20'hFFFFF, 8'hA5}};
    vt[2] = '{2, 20'h00041, 8'h12, 2, 5'h08, 1'b1, 1'b0, 31'd0};
    vt[3] = '{3, 20'h00040, 8'h36, 2, 5'h08, 1'b1, 1'b1, {3'd3, 20'h00040, 8'h36}};
    vt[4] = '{4, 20'h00000, 8'h08, 2, 5'h1F, 1'b1, 1'b1, {3'd4, 20'h00000, 8'h08}};
    vt[5] = '{1, 20'h12345, 8'h77, 1, 5'h1F, 1'b0, 1'b0, 31'd0};
    vt[6] = '{2, 20'h003F8, 8'hC3, 1, 5'h04, 1'b1, 1'b1, {3'd2, 20'h003F8, 8'hC3}};
    for (int i = 0; i < 7; i++) begin
      do_clear();
      type_mask  = vt[i].mask;
      capture_en = vt[i].cap;
      bus_cycle(vt[i].t, vt[i].a, vt[i].d, vt[i].nlow);
      chk($sformatf("vec%0d.valid", i), 64'(rd_valid), 64'(vt[i].exp_valid));
      chk($sformatf("vec%0d.level", i), 64'(level), 64'(vt[i].exp_valid));
      if (vt[i].exp_valid) chk($sformatf("vec%0d.rec", i), 64'(rd_data[30:0]), 64'(vt[i].exp_rec));
    end
    capture_en = 1'b1;
    type_mask  = 5'h1F;

    // IOWR then IORD with only IOWR enabled: one record
    do_clear();
    type_mask = 5'b01000;
    bus_cycle(3, 20'h00040, 8'h36, 1);
    bus_cycle(2, 20'h00041, 8'h12, 1);
    chk("filt.level", 64'(level), 64'd1);
    chk("filt.rec", 64'(rd_data[30:0]), 64'({3'd3, 20'h00040, 8'h36}));
    type_mask = 5'h1F;

    // Last low cycle's data wins
    do_clear();
    bus_addr = 20'h00200;
    bus_data = 8'h11;
    sn       = 5'b11101;
    tick();
    bus_addr = 20'h00201;
    bus_data = 8'h22;
    tick();
    sn = 5'h1F;
    tick();
    chk("last.rec", 64'(rd_data[30:0]), 64'({3'd1, 20'h00201, 8'h22}));

    // Stop mode: 18 MEMRD into 16 entries
    do_clear();
    ring_mode = 1'b0;
    for (int i = 1; i <= 18; i++) bus_cycle(0, 20'(32'h100 + i), 8'(i), 1);
    chk("stop.level", 64'(level), 64'd16);
    chk("stop.ovf", 64'(overflow), 64'd1);
    chk("stop.drops", 64'(drop_cnt), 64'd2);
    chk("stop.head", 64'(rd_data[30:0]), 64'({3'd0, 20'h00101, 8'h01}));

    // Ring mode: oldest two overwritten, drain checks order up to the 18th
    do_clear();
    ring_mode = 1'b1;
    for (int i = 1; i <= 18; i++) bus_cycle(0, 20'(32'h100 + i), 8'(i), 1);
    chk("ring.level", 64'(level), 64'd16);
    chk("ring.drops", 64'(drop_cnt), 64'd2);
    chk("ring.head", 64'(rd_data[30:0]), 64'({3'd0, 20'h00103, 8'h03}));
    for (int i = 0; i < 15; i++) pop_check("ring.drain");
    chk("ring.tail", 64'(rd_data[30:0]), 64'({3'd0, 20'h00112, 8'h12}));
    pop_check("ring.last");
    chk("ring.empty", 64'(rd_valid), 64'd0);
    ring_mode = 1'b0;

    // Full with push and pop on the same edge
    do_clear();
    for (int i = 0; i < 16; i++) bus_cycle(1, 20'(32'h400 + i), 8'(i), 1);
    bus_addr = 20'h00555;
    bus_data = 8'hEE;
    sn       = 5'b11101;
    tick();
    sn       = 5'h1F;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    void'(mq.pop_front());
    mq.push_back(mk(1, 20'h00555, 8'hEE));
    chk("fpp.level", 64'(level), 64'd16);
    chk("fpp.ovf", 64'(overflow), 64'd0);
    chk("fpp.head", 64'(rd_data[30:0]), 64'({3'd1, 20'h00401, 8'h01}));
    check_state("fpp");

    // Two strobes together: one MEMRD record, proto_err set; clear wipes it
    do_clear();
    bus_addr = 20'h00777;
    bus_data = 8'h3C;
    sn       = 5'b11010;
    repeat (2) tick();
    sn = 5'h1F;
    tick();
    chk("proto.flag", 64'(proto_err), 64'd1);
    chk("proto.level", 64'(level), 64'd1);
    chk("proto.rec", 64'(rd_data[30:0]), 64'({3'd0, 20'h00777, 8'h3C}));
    do_clear();
    chk("clr.level", 64'(level), 64'd0);
    chk("clr.proto", 64'(proto_err), 64'd0);
    chk("clr.ovf", 64'(overflow), 64'd0);

    // Clear on the completion edge discards the push
    sn = 5'b10111;
    tick();
    sn    = 5'h1F;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrpush.level", 64'(level), 64'd0);

    // Reset with a strobe held low; its rise after release is logged
    bus_addr = 20'h00ABC;
    bus_data = 8'h99;
    sn       = 5'b11110;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sn = 5'h1F;
    tick();
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    chk("rstmid.level", 64'(level), 64'd1);
    chk("rstmid.rec", 64'(rd_data[30:0]), 64'({3'd0, 20'h00ABC, 8'h99}));
    do_clear();

    // Randomized traffic against the queue model
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        type_mask  = 5'($urandom);
        ring_mode  = 1'($urandom);
        capture_en = ($urandom_range(0, 4) != 0);
      end else if (r <= 3 && mq.size() != 0) begin
        pop_check("rnd");
      end else begin
        bus_cycle($urandom_range(0, 4), 20'($urandom), 8'($urandom), $urandom_range(1, 3));
      end
      if (it % 8 == 0) check_state("rnd");
    end
    check_state("rnd.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
